// File: rtl/timeout_sync_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timeout_sync_timer_pkg
//  Description : Shared types and constants for the one-shot timeout timer.
//  Revision    : 1.0  initial release
// ============================================================================
package timeout_sync_timer_pkg;

   // Default counter width; the longest timeout is 2**width - 1 cycles.
   localparam int unsigned C_DEFAULT_COUNTER_WIDTH = 4;

   // Two-state control: either counting down or waiting for a trigger.
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } run_state_e;

endpackage : timeout_sync_timer_pkg
`default_nettype wire

// File: rtl/timeout_sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : timeout_sync_edge_det
//  Description : Registers the start input and flags a 0->1 transition
//                between consecutive samples. The history register clears
//                on reset, so a level held high through reset release
//                produces exactly one rise.
//  Revision    : 1.0  initial release
// ============================================================================
module timeout_sync_edge_det (
   input  logic clk_in,
   input  logic reset,
   input  logic start,
   output logic rise
);

   logic start_q;
   logic start_d;

   // Next history value is simply the current sample.
   always_comb begin
      start_d = start;
   end

   // History register, cleared by synchronous reset.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         start_q <= 1'b0;
      end else begin
         start_q <= start_d;
      end
   end

   // Rise is high when the current sample is 1 and the previous one was 0.
   always_comb begin
      rise = start & ~start_q;
   end

endmodule : timeout_sync_edge_det
`default_nettype wire

// File: rtl/timeout_sync_timer.sv
`default_nettype none
// ============================================================================
//  Module      : timeout_sync_timer
//  Description : Synchronous one-shot timeout counter. A rising edge on start
//                loads value; running stays high for exactly value cycles,
//                starting the cycle after the trigger edge. counter shows the
//                remaining cycles. value == 0 leaves the timer idle.
//  Config      : TIMEOUT_SYNC_RETRIGGER_EN - when defined, a trigger while
//                running reloads the counter; otherwise it is ignored and the
//                current countdown completes unchanged.
//  Revision    : 1.0  initial release
// ============================================================================
module timeout_sync_timer
   import timeout_sync_timer_pkg::*;
#(
   parameter int unsigned COUNTER_WIDTH = C_DEFAULT_COUNTER_WIDTH
) (
   input  logic                     clk_in,
   input  logic                     reset,
   input  logic                     start,
   input  logic [COUNTER_WIDTH-1:0] value,
   output logic [COUNTER_WIDTH-1:0] counter,
   output logic                     running
);

   logic                     trig;
   logic                     value_nz;
   run_state_e               state_q;
   run_state_e               state_d;
   logic [COUNTER_WIDTH-1:0] counter_q;
   logic [COUNTER_WIDTH-1:0] counter_d;

   timeout_sync_edge_det u_edge_det (
      .clk_in (clk_in),
      .reset  (reset),
      .start  (start),
      .rise   (trig)
   );

   // A zero-length request never enters the running state.
   always_comb begin
      value_nz = (value != '0);
   end

   // Next-state and next-count logic; defaults hold the current state.
   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      case (state_q)
         ST_IDLE: begin
            counter_d = '0;
            if (trig && value_nz) begin
               counter_d = value;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
`ifdef TIMEOUT_SYNC_RETRIGGER_EN
            if (trig) begin
               counter_d = value;
               state_d   = value_nz ? ST_RUN : ST_IDLE;
            end else
`endif
            // Counter is always >= 1 here; the <= guards against ever
            // stepping below zero.
            if (counter_q <= COUNTER_WIDTH'(1)) begin
               counter_d = '0;
               state_d   = ST_IDLE;
            end else begin
               counter_d = counter_q - COUNTER_WIDTH'(1);
            end
         end
         default: begin
            counter_d = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // State and count registers; reset has priority over any trigger.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         counter_q <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      counter = counter_q;
      running = (state_q == ST_RUN);
   end

endmodule : timeout_sync_timer
`default_nettype wire

// File: tb/tb_timeout_sync_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timeout_sync_timer
//  Description : Directed self-checking bench for timeout_sync_timer
//                (COUNTER_WIDTH = 4). Honours TIMEOUT_SYNC_RETRIGGER_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_timeout_sync_timer;

   localparam int unsigned W = 4;

   logic         clk_in;
   logic         reset;
   logic         start;
   logic [W-1:0] value;
   logic [W-1:0] counter;
   logic         running;

   int total;
   int bad;

   timeout_sync_timer #(.COUNTER_WIDTH(W)) dut (
      .clk_in  (clk_in),
      .reset   (reset),
      .start   (start),
      .value   (value),
      .counter (counter),
      .running (running)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Advance one edge; inputs change and outputs are sampled 1 ns later.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // Reset held with start high, then release with start still high:
   // exactly one trigger must follow.
   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      value = 4'd4;
      for (int k = 0; k < 3; k++) begin
         tick();
         total++;
         if ({running, counter} !== {1'b0, 4'd0}) begin
            bad++;
            $display("FAIL reset[%0d]: running=%0b counter=%0d expected running=0 counter=0", k, running, counter);
         end
      end
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         logic [W-1:0] ec;
         logic         er;
         tick();
         er = (k <= 4);
         ec = er ? W'(5 - k) : W'(0);
         total++;
         if ({running, counter} !== {er, ec}) begin
            bad++;
            $display("FAIL reset_release[%0d]: running=%0b counter=%0d expected running=%0b counter=%0d", k, running, counter, er, ec);
         end
      end
   endtask

   // value=15 with start held high: 15 cycles high, no second pulse.
   task automatic test_basic();
      int high;
      start = 1'b0;
      tick();
      value = 4'd15;
      start = 1'b1;
      high  = 0;
      for (int k = 1; k <= 20; k++) begin
         logic [W-1:0] ec;
         logic         er;
         tick();
         er = (k <= 15);
         ec = er ? W'(16 - k) : W'(0);
         if (running) high++;
         total++;
         if ({running, counter} !== {er, ec}) begin
            bad++;
            $display("FAIL basic[%0d]: running=%0b counter=%0d expected running=%0b counter=%0d", k, running, counter, er, ec);
         end
      end
      total++;
      if (high !== 15) begin
         bad++;
         $display("FAIL basic_len: high_cycles=%0d expected=15", high);
      end
   endtask

   // One-cycle reset, start rises on the edge reset falls.
   task automatic test_power_on();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      total++;
      if ({running, counter} !== {1'b0, 4'd0}) begin
         bad++;
         $display("FAIL power_on_rst: running=%0b counter=%0d expected running=0 counter=0", running, counter);
      end
      reset = 1'b0;
      start = 1'b1;
      value = 4'd15;
      for (int k = 1; k <= 18; k++) begin
         logic [W-1:0] ec;
         logic         er;
         tick();
         er = (k <= 15);
         ec = er ? W'(16 - k) : W'(0);
         total++;
         if ({running, counter} !== {er, ec}) begin
            bad++;
            $display("FAIL power_on[%0d]: running=%0b counter=%0d expected running=%0b counter=%0d", k, running, counter, er, ec);
         end
      end
   endtask

   // value=0 is a no-op; value=1 gives a single-cycle pulse.
   task automatic test_value_edges();
      start = 1'b0;
      tick();
      value = 4'd0;
      start = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         tick();
         total++;
         if ({running, counter} !== {1'b0, 4'd0}) begin
            bad++;
            $display("FAIL value0[%0d]: running=%0b counter=%0d expected running=0 counter=0", k, running, counter);
         end
      end
      start = 1'b0;
      tick();
      value = 4'd1;
      start = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         logic [W-1:0] ec;
         logic         er;
         tick();
         er = (k == 1);
         ec = er ? 4'd1 : 4'd0;
         total++;
         if ({running, counter} !== {er, ec}) begin
            bad++;
            $display("FAIL value1[%0d]: running=%0b counter=%0d expected running=%0b counter=%0d", k, running, counter, er, ec);
         end
      end
   endtask

   // value=5; a second rise replaces the step that would have shown 2.
   task automatic test_retrigger();
      int high;
      start = 1'b0;
      tick();
      value = 4'd5;
      start = 1'b1;
      high  = 0;
      for (int k = 1; k <= 11; k++) begin
         logic [W-1:0] ec;
         logic         er;
         tick();
         if (k == 1) start = 1'b0;
         if (k == 3) start = 1'b1;
`ifdef TIMEOUT_SYNC_RETRIGGER_EN
         er = (k <= 8);
         ec = !er ? W'(0) : (k <= 3) ? W'(6 - k) : W'(9 - k);
`else
         er = (k <= 5);
         ec = er ? W'(6 - k) : W'(0);
`endif
         if (running) high++;
         total++;
         if ({running, counter} !== {er, ec}) begin
            bad++;
            $display("FAIL retrigger[%0d]: running=%0b counter=%0d expected running=%0b counter=%0d", k, running, counter, er, ec);
         end
      end
      total++;
`ifdef TIMEOUT_SYNC_RETRIGGER_EN
      if (high !== 8) begin
         bad++;
         $display("FAIL retrigger_len: high_cycles=%0d expected=8", high);
      end
`else
      if (high !== 5) begin
         bad++;
         $display("FAIL retrigger_len: high_cycles=%0d expected=5", high);
      end
`endif
   endtask

   // value=10, reset when counter shows 6, then a clean restart.
   task automatic test_mid_reset();
      start = 1'b0;
      tick();
      value = 4'd10;
      start = 1'b1;
      for (int k = 1; k <= 5; k++) tick();
      total++;
      if ({running, counter} !== {1'b1, 4'd6}) begin
         bad++;
         $display("FAIL mid_pre: running=%0b counter=%0d expected running=1 counter=6", running, counter);
      end
      reset = 1'b1;
      start = 1'b0;
      tick();
      total++;
      if ({running, counter} !== {1'b0, 4'd0}) begin
         bad++;
         $display("FAIL mid_abort: running=%0b counter=%0d expected running=0 counter=0", running, counter);
      end
      reset = 1'b0;
      tick();
      total++;
      if ({running, counter} !== {1'b0, 4'd0}) begin
         bad++;
         $display("FAIL mid_idle: running=%0b counter=%0d expected running=0 counter=0", running, counter);
      end
      value = 4'd3;
      start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         logic [W-1:0] ec;
         logic         er;
         tick();
         er = (k <= 3);
         ec = er ? W'(4 - k) : W'(0);
         total++;
         if ({running, counter} !== {er, ec}) begin
            bad++;
            $display("FAIL mid_restart[%0d]: running=%0b counter=%0d expected running=%0b counter=%0d", k, running, counter, er, ec);
         end
      end
   endtask

   // A fresh rise on the first idle edge after a pulse starts a new one.
   task automatic test_back_to_back();
      start = 1'b0;
      tick();
      value = 4'd2;
      start = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         logic [W-1:0] ec;
         logic         er;
         tick();
         if (k == 1) start = 1'b0;
         if (k == 3) start = 1'b1;
         case (k)
            1: begin er = 1'b1; ec = 4'd2; end
            2: begin er = 1'b1; ec = 4'd1; end
            3: begin er = 1'b0; ec = 4'd0; end
            4: begin er = 1'b1; ec = 4'd2; end
            5: begin er = 1'b1; ec = 4'd1; end
            default: begin er = 1'b0; ec = 4'd0; end
         endcase
         total++;
         if ({running, counter} !== {er, ec}) begin
            bad++;
            $display("FAIL back_to_back[%0d]: running=%0b counter=%0d expected running=%0b counter=%0d", k, running, counter, er, ec);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      start = 1'b0;
      value = '0;
      test_reset();
      test_basic();
      test_power_on();
      test_value_edges();
      test_retrigger();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_timeout_sync_timer
`default_nettype wire
